// File: rtl/conv_out_collector.sv
// Captures 8-lane {c1,c2,c3} triplets into a small FIFO and serialises them as
// addressed write beats. Optional ReLU clamp on the output lanes: CONV_OUT_RELU_EN.
module conv_out_collector #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FRAME_WORDS = 192,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       c1 [7:0],
  input  logic [DATA_WIDTH-1:0]       c2 [7:0],
  input  logic [DATA_WIDTH-1:0]       c3 [7:0],
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [DATA_WIDTH-1:0]       wr_data [7:0],
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic                        frame_done,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0]         FULL_LVL   = LW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS - 1);

  typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, W2 = 2'd2} beat_e;

  beat_e                 beat_q, beat_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH][3][8];

  logic push, fire, pop;
  logic [1:0] word_sel;

  always_comb begin
    push         = in_valid && (level_q != FULL_LVL);
    fire         = (level_q != '0) && wr_ready;
    pop          = fire && (beat_q == W2);
    beat_d       = beat_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    addr_d       = addr_q;
    overflow_d   = overflow_q | (in_valid && (level_q == FULL_LVL));
    frame_done_d = fire && (addr_q == LAST_ADDR);

    if (fire) begin
      case (beat_q)
        W0:      beat_d = W1;
        W1:      beat_d = W2;
        default: beat_d = W0;
      endcase
      addr_d = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + ADDR_WIDTH'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // Fullness was judged on level_q, so a push and pop on one edge cancel.
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q       <= W0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      addr_q       <= FIRST_ADDR;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      beat_q       <= beat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      addr_q       <= addr_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset: validity is carried entirely by level_q.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem_q[wr_ptr_q][0][i] <= c1[i];
        mem_q[wr_ptr_q][1][i] <= c2[i];
        mem_q[wr_ptr_q][2][i] <= c3[i];
      end
    end
  end

  always_comb begin
    word_sel = beat_q;
    for (int unsigned i = 0; i < 8; i++) begin
`ifdef CONV_OUT_RELU_EN
      wr_data[i] = mem_q[rd_ptr_q][word_sel][i][DATA_WIDTH-1] ? '0 : mem_q[rd_ptr_q][word_sel][i];
`else
      wr_data[i] = mem_q[rd_ptr_q][word_sel][i];
`endif
    end
  end

  assign wr_valid   = (level_q != '0);
  assign wr_addr    = addr_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule
